// File: rtl/gpu_pkg.sv
// Shared display-path constants: default 640x480@60 raster timing and colour widths.
package gpu_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned CHAN_W  = 4;

  // 4:4:4 pixel as delivered by the display stage, red in the top nibble
  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/gpu_clk_enable.sv
// Integer clock-enable divider: one-clk tick every CLK_DIV system clocks.
module gpu_clk_enable #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // tick follows the clock on which the divider sits at its last count
  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_LAST);
      div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/gpu_vga_timing.sv
// Raster counters, sync decode and the blanked RGB/sync output register for VGA.
module gpu_vga_timing
  import gpu_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CNT_W-1:0]   row,
  output logic [CNT_W-1:0]   col,
  output logic               pixelTick,
  output logic               displayActive,
  input  logic [COLOR_W-1:0] vgaIn,
  output logic [CHAN_W-1:0]  vgaR,
  output logic [CHAN_W-1:0]  vgaG,
  output logic [CHAN_W-1:0]  vgaB,
  output logic               hSync,
  output logic               vSync,
  output logic               frameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // one spare bit so sync-end bounds equal to 1024 still compare correctly
  localparam int unsigned CMP_W   = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CMP_W-1:0] H_ACT  = CMP_W'(H_VISIBLE);
  localparam logic [CMP_W-1:0] V_ACT  = CMP_W'(V_VISIBLE);
  localparam logic [CMP_W-1:0] HS_BEG = CMP_W'(H_VISIBLE + H_FRONT);
  localparam logic [CMP_W-1:0] HS_END = CMP_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CMP_W-1:0] VS_BEG = CMP_W'(V_VISIBLE + V_FRONT);
  localparam logic [CMP_W-1:0] VS_END = CMP_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CMP_W-1:0] col_x;
  logic [CMP_W-1:0] row_x;
  logic             h_sync_c;
  logic             v_sync_c;
  logic             col_last_c;
  logic             row_last_c;
  rgb_t             pix_c;

  gpu_clk_enable #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_enable (
    .clk (clk),
    .rst (rst),
    .tick(pixelTick)
  );

  assign col_x = {1'b0, col};
  assign row_x = {1'b0, row};

  // decode of the current position; display stage colour is valid for the same position
  always_comb begin
    displayActive = 1'b0;
    h_sync_c      = ~SYNC_ACTIVE;
    v_sync_c      = ~SYNC_ACTIVE;
    col_last_c    = 1'b0;
    row_last_c    = 1'b0;
    pix_c         = '0;
    displayActive = (col_x < H_ACT) && (row_x < V_ACT);
    if ((col_x >= HS_BEG) && (col_x < HS_END)) h_sync_c = SYNC_ACTIVE;
    if ((row_x >= VS_BEG) && (row_x < VS_END)) v_sync_c = SYNC_ACTIVE;
    col_last_c = (col == H_LAST);
    row_last_c = (row == V_LAST);
    if (displayActive) pix_c = rgb_t'(vgaIn);
  end

  // counters and output register advance together, so RGB and syncs share one pixel of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      vgaR       <= '0;
      vgaG       <= '0;
      vgaB       <= '0;
      hSync      <= ~SYNC_ACTIVE;
      vSync      <= ~SYNC_ACTIVE;
      frameStart <= 1'b0;
    end else begin
      frameStart <= 1'b0;
      if (pixelTick) begin
        vgaR  <= pix_c.r;
        vgaG  <= pix_c.g;
        vgaB  <= pix_c.b;
        hSync <= h_sync_c;
        vSync <= v_sync_c;
        if (col_last_c) begin
          col <= '0;
          if (row_last_c) begin
            row        <= '0;
            frameStart <= 1'b1;
          end else begin
            row <= row + CNT_W'(1);
          end
        end else begin
          col <= col + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_vga_timing.sv
// Bench: default-mode DUT (CLK_DIV=2) for line-level checks, short-frame DUT (CLK_DIV=1) for frame checks.
module tb_gpu_vga_timing;

  typedef struct {
    int key;
    int row;
    int col;
    int rgb;
    int hs;
    int vs;
    int fs;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int str_err  = 0;

  rec_t a_q[$];
  rec_t b_q[$];

  logic       rst_a, rst_b;
  logic [9:0] a_row, a_col, b_row, b_col;
  logic       a_tick, a_de, a_hs, a_vs, a_fs;
  logic       b_tick, b_de, b_hs, b_vs, b_fs;
  logic [11:0] a_vin, b_vin;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  int a_cyc = 0;
  int b_cyc = 0;
  int a_hs_low = 0;
  int a_hs_first = -1;
  int b_vs_low = 0;
  int b_fs_cnt = 0;
  bit b_run = 1'b0;

  // display-stage stand-in: colour is a pure function of the position it is shown
  function automatic logic [11:0] pattern(input logic [9:0] r, input logic [9:0] c);
    if (r == 10'd5 && c == 10'd100) return 12'hABC;
    if (c >= 10'd640) return 12'hFFF;
    return {c[3:0], r[3:0], c[7:4]};
  endfunction

  assign a_vin = pattern(a_row, a_col);
  assign b_vin = pattern(b_row, b_col);

  gpu_vga_timing #(
    .CLK_DIV(2)
  ) dut_a (
    .clk(clk), .rst(rst_a), .row(a_row), .col(a_col), .pixelTick(a_tick),
    .displayActive(a_de), .vgaIn(a_vin), .vgaR(a_r), .vgaG(a_g), .vgaB(a_b),
    .hSync(a_hs), .vSync(a_vs), .frameStart(a_fs)
  );

  gpu_vga_timing #(
    .CLK_DIV(1), .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .row(b_row), .col(b_col), .pixelTick(b_tick),
    .displayActive(b_de), .vgaIn(b_vin), .vgaR(b_r), .vgaG(b_g), .vgaB(b_b),
    .hSync(b_hs), .vSync(b_vs), .frameStart(b_fs)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic stream(input string name, input int key, input int act, input int exp);
    if (act != exp) begin
      str_err++;
      if (str_err <= 10) $display("FAIL %s@%0d: got %0d, expected %0d", name, key, act, exp);
    end
  endtask

  function automatic rec_t mk(input int key, input int row, input int col, input int rgb,
                              input int hs, input int vs, input int fs);
    rec_t e;
    e.key = key; e.row = row; e.col = col; e.rgb = rgb; e.hs = hs; e.vs = vs; e.fs = fs;
    return e;
  endfunction

  task automatic sb_compare(input string tag, input rec_t e, input int row, input int col,
                            input int rgb, input int hs, input int vs, input int fs);
    check($sformatf("%s_row@%0d", tag, e.key), row, e.row);
    check($sformatf("%s_col@%0d", tag, e.key), col, e.col);
    if (e.rgb >= 0) check($sformatf("%s_rgb@%0d", tag, e.key), rgb, e.rgb);
    check($sformatf("%s_hsync@%0d", tag, e.key), hs, e.hs);
    check($sformatf("%s_vsync@%0d", tag, e.key), vs, e.vs);
    check($sformatf("%s_frame_start@%0d", tag, e.key), fs, e.fs);
  endtask

  // clocks since reset release, counted on the bench side
  always @(posedge clk) begin
    a_cyc <= rst_a ? 0 : a_cyc + 1;
    b_cyc <= rst_b ? 0 : b_cyc + 1;
  end

  // monitor A: at pixel tick k the counters show pixel k and the outputs hold pixel k-1
  always @(negedge clk) begin
    int k, r, c, q, qr, qc, er, eh, ev;
    rec_t e;
    if (a_cyc > 0) begin
      stream("a_tick", a_cyc, int'(a_tick), int'(a_cyc % 2 == 0));
      if (a_tick === 1'b1) begin
        k = a_cyc / 2 - 1;
        r = (k / 800) % 525;
        c = k % 800;
        stream("a_row", k, int'(a_row), r);
        stream("a_col", k, int'(a_col), c);
        stream("a_active", k, int'(a_de), int'(c < 640 && r < 480));
        stream("a_frame_start", k, int'(a_fs), 0);
        er = 0; eh = 1; ev = 1; qr = -1; qc = -1;
        if (k > 0) begin
          q  = k - 1;
          qr = (q / 800) % 525;
          qc = q % 800;
          er = (qc < 640 && qr < 480) ? int'(pattern(10'(qr), 10'(qc))) : 0;
          eh = (qc >= 656 && qc < 752) ? 0 : 1;
          ev = (qr >= 490 && qr < 492) ? 0 : 1;
        end
        stream("a_rgb", k, int'({a_r, a_g, a_b}), er);
        stream("a_hsync", k, int'(a_hs), eh);
        stream("a_vsync", k, int'(a_vs), ev);
        if (qr == 5 && a_hs === 1'b0) begin
          if (a_hs_low == 0) a_hs_first = qc;
          a_hs_low++;
        end
        while (a_q.size() > 0 && a_q[0].key <= k) begin
          e = a_q.pop_front();
          if (e.key < k) check("a_sb_missed", k, e.key);
          else sb_compare("a", e, int'(a_row), int'(a_col), int'({a_r, a_g, a_b}),
                          int'(a_hs), int'(a_vs), int'(a_fs));
        end
      end
    end
  end

  // monitor B: tick every clock, pixel index is clocks since release minus one; 8-line frame
  always @(negedge clk) begin
    int p, pf, r, c, q, qr, qc, er, eh, ev;
    rec_t e;
    if (b_cyc > 0) begin
      stream("b_tick", b_cyc, int'(b_tick), 1);
      if (b_tick === 1'b1) begin
        p  = b_cyc - 1;
        pf = p % 6400;
        r  = pf / 800;
        c  = pf % 800;
        stream("b_row", b_cyc, int'(b_row), r);
        stream("b_col", b_cyc, int'(b_col), c);
        stream("b_active", b_cyc, int'(b_de), int'(c < 640 && r < 4));
        stream("b_frame_start", b_cyc, int'(b_fs), int'(p > 0 && pf == 0));
        er = 0; eh = 1; ev = 1; q = -1;
        if (p > 0) begin
          q  = p - 1;
          qr = (q % 6400) / 800;
          qc = q % 800;
          er = (qc < 640 && qr < 4) ? int'(pattern(10'(qr), 10'(qc))) : 0;
          eh = (qc >= 656 && qc < 752) ? 0 : 1;
          ev = (qr >= 5 && qr < 7) ? 0 : 1;
        end
        stream("b_rgb", b_cyc, int'({b_r, b_g, b_b}), er);
        stream("b_hsync", b_cyc, int'(b_hs), eh);
        stream("b_vsync", b_cyc, int'(b_vs), ev);
        if (!b_run) begin
          if (b_fs === 1'b1) b_fs_cnt++;
          if (q >= 0 && q < 6400 && b_vs === 1'b0) b_vs_low++;
        end
        while (b_q.size() > 0 && b_q[0].key <= b_cyc) begin
          e = b_q.pop_front();
          if (e.key < b_cyc) check("b_sb_missed", b_cyc, e.key);
          else sb_compare("b", e, int'(b_row), int'(b_col), -1,
                          int'(b_hs), int'(b_vs), int'(b_fs));
        end
      end
    end
  end

  task automatic stim_a();
    rst_a = 1'b1;
    // key = tick index; outputs belong to the previous pixel
    a_q.push_back(mk(0,    0, 0,   12'h000, 1, 1, 0));
    a_q.push_back(mk(19,   0, 19,  12'h201, 1, 1, 0));
    a_q.push_back(mk(4001, 5, 1,   12'h050, 1, 1, 0));
    a_q.push_back(mk(4101, 5, 101, 12'hABC, 1, 1, 0));
    a_q.push_back(mk(4640, 5, 640, 12'hF57, 1, 1, 0));
    a_q.push_back(mk(4641, 5, 641, 12'h000, 1, 1, 0));
    a_q.push_back(mk(4656, 5, 656, 12'h000, 1, 1, 0));
    a_q.push_back(mk(4657, 5, 657, 12'h000, 0, 1, 0));
    a_q.push_back(mk(4752, 5, 752, 12'h000, 0, 1, 0));
    a_q.push_back(mk(4753, 5, 753, 12'h000, 1, 1, 0));
    a_q.push_back(mk(4799, 5, 799, 12'h000, 1, 1, 0));
    a_q.push_back(mk(4800, 6, 0,   12'h000, 1, 1, 0));
    repeat (3) @(negedge clk);
    check("a_reset_row", int'(a_row), 0);
    check("a_reset_col", int'(a_col), 0);
    check("a_reset_rgb", int'({a_r, a_g, a_b}), 0);
    check("a_reset_hsync", int'(a_hs), 1);
    check("a_reset_vsync", int'(a_vs), 1);
    check("a_reset_tick", int'(a_tick), 0);
    check("a_reset_frame_start", int'(a_fs), 0);
    rst_a = 1'b0;
    @(negedge clk) check("a_tick_clk1", int'(a_tick), 0);
    @(negedge clk) check("a_tick_clk2", int'(a_tick), 1);
    @(negedge clk) check("a_tick_clk3", int'(a_tick), 0);
    @(negedge clk) check("a_tick_clk4", int'(a_tick), 1);
    repeat (9620) @(negedge clk);
    check("a_hsync_low_ticks_row5", a_hs_low, 96);
    check("a_hsync_first_low_col", a_hs_first, 656);
    check("a_sb_unconsumed", a_q.size(), 0);
  endtask

  task automatic stim_b();
    rst_b = 1'b1;
    // key = clocks since release; vSync rows are 5..6 in this geometry
    b_q.push_back(mk(1,     0, 0,   -1, 1, 1, 0));
    b_q.push_back(mk(801,   1, 0,   -1, 1, 1, 0));
    b_q.push_back(mk(4001,  5, 0,   -1, 1, 1, 0));
    b_q.push_back(mk(4002,  5, 1,   -1, 1, 0, 0));
    b_q.push_back(mk(5601,  7, 0,   -1, 1, 0, 0));
    b_q.push_back(mk(5602,  7, 1,   -1, 1, 1, 0));
    b_q.push_back(mk(6400,  7, 799, -1, 1, 1, 0));
    b_q.push_back(mk(6401,  0, 0,   -1, 1, 1, 1));
    b_q.push_back(mk(6402,  0, 1,   -1, 1, 1, 0));
    b_q.push_back(mk(12801, 0, 0,   -1, 1, 1, 1));
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 20000 && b_cyc != 15601; i++) @(negedge clk);
    check("b_wait_mid_frame", b_cyc, 15601);
    check("b_mid_row", int'(b_row), 3);
    check("b_mid_col", int'(b_col), 400);
    check("b_fs_pulses_two_frames", b_fs_cnt, 2);
    check("b_vsync_low_clks_frame0", b_vs_low, 1600);
    b_run = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("b_midreset_row", int'(b_row), 0);
    check("b_midreset_col", int'(b_col), 0);
    check("b_midreset_tick", int'(b_tick), 0);
    check("b_midreset_rgb", int'({b_r, b_g, b_b}), 0);
    check("b_midreset_hsync", int'(b_hs), 1);
    check("b_midreset_vsync", int'(b_vs), 1);
    check("b_midreset_frame_start", int'(b_fs), 0);
    rst_b = 1'b0;
    b_q.push_back(mk(1,    0, 0, -1, 1, 1, 0));
    b_q.push_back(mk(801,  1, 0, -1, 1, 1, 0));
    b_q.push_back(mk(6401, 0, 0, -1, 1, 1, 1));
    repeat (6500) @(negedge clk);
    check("b_sb_unconsumed", b_q.size(), 0);
  endtask

  initial begin
    fork
      stim_a();
      stim_b();
    join
    check("stream_errors", str_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
